// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache: hits answer in the request cycle (0 latency).
// Misses hold proc_stall high through an optional victim write-back and a refill, then replay as a hit.
module dcache_ctrl #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WBACK, ALLOC} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [6:0]         word_lsb;
    logic               req, hit, idle, rd_hit, wr_hit, fill;

    assign idx      = proc_addr[INDEX_W+1:2];
    assign req_tag  = proc_addr[29:INDEX_W+2];
    assign word_lsb = {proc_addr[1:0], 5'b0};
    assign req      = proc_read | proc_write;
    assign idle     = (state_q == IDLE);
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
    // a simultaneous read+write is serviced as a write
    assign wr_hit   = idle && proc_write && hit;
    assign rd_hit   = idle && proc_read && !proc_write && hit;
    assign fill     = (state_q == ALLOC) && mem_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        case (state_q)
            IDLE: begin
                if (req && !hit)
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WBACK : ALLOC;
                else if (wr_hit)
                    dirty_d[idx] = 1'b1;
            end
            WBACK: begin
                if (mem_ready)
                    state_d = ALLOC;
            end
            ALLOC: begin
                if (mem_ready) begin
                    state_d      = IDLE;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= req_tag;
        end else if (wr_hit) begin
            data_q[idx][word_lsb +: 32] <= proc_wdata;
        end
    end

    assign mem_read  = (state_q == ALLOC);
    assign mem_write = (state_q == WBACK);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WBACK: begin
                mem_addr  = {tag_q[idx], idx};
                mem_wdata = data_q[idx];
            end
            ALLOC:   mem_addr = proc_addr[29:2];
            default: ;
        endcase
    end

    assign proc_stall = rst_n && (!idle || (req && !hit));
    assign proc_rdata = (rst_n && rd_hit) ? data_q[idx][word_lsb +: 32] : 32'h0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl: a flat-memory reference predicts read data and memory traffic,
// a memory responder and a processor-side monitor pop the predictions and compare.
module tb_dcache_ctrl;

    localparam int INDEX_W = 3;
    localparam int LINES   = 1 << INDEX_W;
    localparam int TAG_W   = 30 - INDEX_W - 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall, mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_W(INDEX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mreq_t;

    mreq_t        exp_mem_q[$];
    logic [31:0]  exp_rd_q[$];

    // Backing memory (block granularity) and the architectural word view seen by the CPU.
    logic [127:0] mem_blk [logic [27:0]];
    logic [31:0]  arch    [logic [29:0]];
    bit           mv [LINES];
    bit           md [LINES];
    logic [TAG_W-1:0] mt [LINES];

    int fixed_delay = 0;
    int wait_cycles = 0;
    int last_stall  = 0;

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C96_A50F;
    endfunction

    function automatic logic [127:0] blk_read(input logic [27:0] ba);
        logic [127:0] r;
        if (mem_blk.exists(ba)) return mem_blk[ba];
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = init_word({ba, 2'(w)});
        return r;
    endfunction

    function automatic logic [31:0] arch_read(input logic [29:0] a);
        logic [127:0] b;
        if (arch.exists(a)) return arch[a];
        b = blk_read(a[29:2]);
        return b[32*a[1:0] +: 32];
    endfunction

    // Memory responder: checks each new request against the prediction, answers after 1..4 cycles.
    initial begin
        int cnt;
        int d;
        mreq_t e;
        cnt = 0;
        d = 1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst_n && (mem_read || mem_write)) begin
                if (cnt == 0) begin
                    d = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
                    if (exp_mem_q.size() == 0) begin
                        checks++;
                        $display("FAIL mem_req: unexpected request wr=%0d addr %0h, none predicted", mem_write, mem_addr);
                    end else begin
                        e = exp_mem_q.pop_front();
                        chk("mem_kind", 128'(mem_write), 128'(e.wr));
                        chk("mem_addr", 128'(mem_addr), 128'(e.addr));
                        if (e.wr) chk("mem_wdata", mem_wdata, e.data);
                    end
                end
                cnt++;
                if (cnt >= d) begin
                    mem_ready = 1'b1;
                    if (mem_write) mem_blk[mem_addr] = mem_wdata;
                    else mem_rdata = blk_read(mem_addr);
                    wait_cycles += d;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Processor-side monitor: read data whenever a read is not stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("mem_rw_excl", 128'(mem_read & mem_write), 128'(0));
                if (!mem_read && !mem_write) begin
                    chk("mem_addr_idle", 128'(mem_addr), 128'(0));
                    chk("mem_wdata_idle", mem_wdata, 128'(0));
                end
                if (proc_stall) begin
                    chk("rdata_stalled", 128'(proc_rdata), 128'(0));
                end else if (proc_read && !proc_write) begin
                    if (exp_rd_q.size() == 0) begin
                        checks++;
                        $display("FAIL rdata: unexpected read response %0h", proc_rdata);
                    end else begin
                        chk("rdata", 128'(proc_rdata), 128'(exp_rd_q.pop_front()));
                    end
                end
            end
        end
    end

    // Predict the outcome of a request from the reference state; returns whether it misses.
    task automatic predict(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] wd, output bit miss);
        logic [INDEX_W-1:0] ix;
        logic [TAG_W-1:0]   tg;
        logic [127:0]       vd;
        ix = a[INDEX_W+1:2];
        tg = a[29:INDEX_W+2];
        miss = !(mv[ix] && mt[ix] == tg);
        if (miss) begin
            if (mv[ix] && md[ix]) begin
                for (int w = 0; w < 4; w++) vd[w*32 +: 32] = arch_read({mt[ix], ix, 2'(w)});
                exp_mem_q.push_back('{wr: 1'b1, addr: {mt[ix], ix}, data: vd});
            end
            exp_mem_q.push_back('{wr: 1'b0, addr: a[29:2], data: 128'(0)});
            mv[ix] = 1'b1;
            mt[ix] = tg;
            md[ix] = 1'b0;
        end
        if (wr) begin
            arch[a] = wd;
            md[ix]  = 1'b1;
        end else if (rd) begin
            exp_rd_q.push_back(arch_read(a));
        end
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] wd);
        bit miss;
        bit done;
        int w0;
        int sc;
        predict(rd, wr, a, wd, miss);
        w0 = wait_cycles;
        @(posedge clk);
        #1;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        done = 1'b0;
        sc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!proc_stall) begin
                done = 1'b1;
                break;
            end
            sc++;
        end
        if (!done) chk("stall_timeout", 128'(1), 128'(0));
        chk("stall_cycles", 128'(sc), miss ? 128'(1 + wait_cycles - w0) : 128'(0));
        last_stall = sc;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        @(negedge clk);
        chk("idle_stall", 128'(proc_stall), 128'(0));
    endtask

    task automatic reset_model();
        for (int i = 0; i < LINES; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        arch.delete();
    endtask

    task automatic random_ops(input int n);
        logic [29:0] a;
        int k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if (k == 0) idle_cycle();
            else if (k <= 5) do_req(1'b1, 1'b0, a, 32'h0);
            else if (k <= 8) do_req(1'b0, 1'b1, a, $urandom);
            else do_req(1'b1, 1'b1, a, $urandom);
        end
    endtask

    initial begin
        bit seen;
        bit miss;
        reset_model();
        rst_n      = 1'b0;
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h10;
        proc_wdata = 32'h0;
        #12;
        chk("rst_stall", 128'(proc_stall), 128'(0));
        chk("rst_rdata", 128'(proc_rdata), 128'(0));
        chk("rst_mem_read", 128'(mem_read), 128'(0));
        chk("rst_mem_write", 128'(mem_write), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        proc_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        mem_blk[28'h4] = {32'hD, 32'hC, 32'hB, 32'hA};
        fixed_delay = 3;
        do_req(1'b1, 1'b0, 30'h10, 32'h0);
        chk("clean_miss_stall4", 128'(last_stall), 128'(4));
        fixed_delay = 0;
        do_req(1'b1, 1'b0, 30'h11, 32'h0);
        do_req(1'b1, 1'b0, 30'h12, 32'h0);
        do_req(1'b1, 1'b0, 30'h13, 32'h0);
        do_req(1'b0, 1'b1, 30'h12, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 30'h12, 32'h0);
        do_req(1'b1, 1'b0, 30'h210, 32'h0);
        do_req(1'b0, 1'b1, 30'h15, 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 30'h215, 32'h0);
        do_req(1'b1, 1'b0, 30'h15, 32'h0);
        idle_cycle();

        random_ops(400);

        // Reset landing in the middle of a refill.
        fixed_delay = 4;
        predict(1'b1, 1'b0, 30'h3F0, 32'h0, miss);
        @(posedge clk);
        #1;
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h3F0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_read) begin
                seen = 1'b1;
                break;
            end
        end
        chk("alloc_reached", 128'(seen), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_read", 128'(mem_read), 128'(0));
        chk("arst_mem_write", 128'(mem_write), 128'(0));
        chk("arst_mem_addr", 128'(mem_addr), 128'(0));
        chk("arst_stall", 128'(proc_stall), 128'(0));
        chk("arst_pending_mem", 128'(exp_mem_q.size()), 128'(0));
        exp_rd_q.delete();
        exp_mem_q.delete();
        reset_model();
        proc_read = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fixed_delay = 0;
        do_req(1'b1, 1'b0, 30'h10, 32'h0);
        chk("post_rst_miss", 128'(last_stall > 0), 128'(1));

        random_ops(60);
        idle_cycle();
        idle_cycle();
        chk("mem_q_drained", 128'(exp_mem_q.size()), 128'(0));
        chk("rd_q_drained", 128'(exp_rd_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller that answers the CacheRead/CacheWrite requests issued from the EX/MEM pipeline stage. On a hit it returns read data or absorbs the write in the same cycle. On a miss it raises `proc_stall` and runs a block write-back and refill against main memory. `proc_stall` feeds the EX/MEM register's `EMWrite` hold input.

## Interface
- `INDEX_W`, default 3: index bits; the cache holds 2^INDEX_W lines of 4 words (128 bits).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `proc_read`  in  1  load request (CacheRead from EX/MEM).
- `proc_write`  in  1  store request (CacheWrite from EX/MEM).
- `proc_addr`  in  30  word address. [1:0] is the word offset, [INDEX_W+1:2] the index, [29:INDEX_W+2] the tag.
- `proc_wdata`  in  32  store data.
- `proc_rdata`  out  32  load data; valid when `proc_read` && !`proc_stall`.
- `proc_stall`  out  1  hold request; the pipeline freezes while high.
- `mem_read`  out  1  block read request.
- `mem_write`  out  1  block write request.
- `mem_addr`  out  28  block address (word address >> 2).
- `mem_wdata`  out  128  victim block; word 0 in [31:0].
- `mem_rdata`  in  128  refill block; word 0 in [31:0].
- `mem_ready`  in  1  one-cycle pulse: the write is accepted, or the refill data is valid.

## Operation
- Per line storage: valid bit, dirty bit, tag of 28-INDEX_W bits, 128-bit data.
- Valid and dirty bits are reset to 0. Tag and data arrays are not reset.
- A hit is valid[idx] && tag[idx]==proc_addr tag, with the FSM in IDLE.
- If `proc_read` and `proc_write` are both high, the request is treated as a write. The requester holds address, data and request stable while `proc_stall`=1.

FSM states: IDLE, WBACK, ALLOC.
- **IDLE, no request:** stall=0, no memory request.
- **IDLE, read hit:** `proc_rdata` = selected word, combinational; stall=0.
- **IDLE, write hit:** stall=0. At the clock edge the selected word takes `proc_wdata` and dirty[idx] is set to 1.
- **IDLE, miss:** stall=1. If valid[idx] && dirty[idx], go to WBACK; otherwise go to ALLOC.
- **WBACK:** `mem_write`=1, `mem_addr`={victim tag, idx}, `mem_wdata`=line data, stall=1. On `mem_ready`, go to ALLOC.
- **ALLOC:** `mem_read`=1, `mem_addr`=proc_addr[29:2], stall=1. On `mem_ready`, write line ← `mem_rdata`, tag ← request tag, valid=1, dirty=0, then go to IDLE.
- The request is re-evaluated in IDLE and now hits. A pending write therefore merges into the refilled line on that hit cycle and sets dirty.
- `mem_read`/`mem_write` are Moore outputs (decoded from state). They are never high together.
- `proc_rdata` is 0 whenever it is not a read hit in IDLE.
- `mem_wdata` and `mem_addr` are 0 in IDLE.

## Timing
- Reset values: state=IDLE; `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- `proc_stall` and `proc_rdata` are 0 under reset, regardless of requests.
- Hit latency is 0: data and no stall in the request cycle.
- Clean miss: if `mem_ready` arrives on the Nth ALLOC cycle (N≥1), stall is high for 1+N cycles and the hit completes on the following cycle.
- Dirty miss: stall is high for 1+M+N cycles, where M is the number of WBACK cycles up to and including `mem_ready`.
- `mem_ready` is ignored in IDLE.
- Reset asserted mid-WBACK or mid-ALLOC: the memory request drops immediately (asynchronously), all lines are invalidated, and the state returns to IDLE. The interrupted fill is not written.
- Back-to-back hits to different lines complete one per cycle with no bubbles.

## Test plan
1. After reset, read addr 0x0000010. Expect stall=1, then ALLOC with `mem_addr`=0x0000004. Return `mem_ready` on the 3rd cycle with `mem_rdata`={32'hD,32'hC,32'hB,32'hA}. Expect 4 stall cycles total, then `proc_rdata`=0xA with stall=0.
2. After scenario 1, read 0x0000011/12/13 on consecutive cycles. Expect 0xB, 0xC, 0xD with stall=0 throughout and no memory request.
3. Write 0xDEADBEEF to 0x0000012 (hit), then read it back. Expect no stall and readback 0xDEADBEEF.
4. Read 0x0000210 (same index as scenario 1, different tag). Expect WBACK first with `mem_addr`=0x0000004 and `mem_wdata`={D,DEADBEEF,B,A}, then ALLOC with `mem_addr`=0x0000084, then a hit.
5. Write miss to a clean line. Expect ALLOC only, never WBACK. The refilled line takes the write word, and a later eviction of that line writes it back.
6. Assert `rst_n`=0 during ALLOC. Expect `mem_read`→0 at once and state IDLE. The previously filled address now misses.
